// File: rtl/conv_xnor_popcount_unit_if.sv
// Column/weight input bus and thresholded result bus of conv_xnor_popcount_unit.
// master drives columns and weights; slave produces the popcount result.
interface conv_xnor_popcount_unit_if #(
  parameter int IDX_W = 4
);
  logic [15:0]      weights_data;
  logic             weights_load;
  logic [2:0]       d_in;
  logic             d_valid;
  logic [IDX_W-1:0] col_idx;
  logic             row_start;
  logic             out_valid;
  logic             out_bit;
  logic [IDX_W-1:0] out_idx;
  logic [3:0]       popcount;

  modport master (
    output weights_data, weights_load, d_in, d_valid, col_idx, row_start,
    input  out_valid, out_bit, out_idx, popcount
  );

  modport slave (
    input  weights_data, weights_load, d_in, d_valid, col_idx, row_start,
    output out_valid, out_bit, out_idx, popcount
  );
endinterface

// File: rtl/conv_xnor_popcount_unit.sv
// 3x3 binary XNOR-popcount over a 3-column sliding window, 2-stage pipeline.
// Optional macro CONV_THRESH_PORT_EN adds a run-time threshold (thresh_in, captured on weights_load).
module conv_xnor_popcount_unit #(
  parameter int THRESH = 5,
  parameter int IDX_W  = 4
) (
  input  logic clk,
  input  logic reset_b,
`ifdef CONV_THRESH_PORT_EN
  input  logic [3:0] thresh_in,
`endif
  conv_xnor_popcount_unit_if.slave bus
);

  localparam logic [3:0] THRESH_V = 4'(THRESH);

  logic [8:0]       weight_reg;
  logic [2:0][2:0]  win_reg;      // win_reg[c][r]: column c (0 = oldest), row r
  logic [1:0]       fill_reg;
  logic [1:0]       fill_next;
  logic             upd_reg;      // window just became (or stayed) full
  logic [IDX_W-1:0] head_reg;

  logic [2:0][1:0]  row_cnt;
  logic [2:0][1:0]  s1_cnt_reg;
  logic [IDX_W-1:0] s1_idx_reg;
  logic             s1_valid_reg;

  logic [3:0]       pop_next;
  logic [3:0]       thr;
  logic             out_valid_reg;
  logic             out_bit_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [3:0]       pop_reg;

  logic             unused_bits;
  assign unused_bits = ^bus.weights_data[15:9];

`ifdef CONV_THRESH_PORT_EN
  logic [3:0] thresh_reg;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      thresh_reg <= THRESH_V;
    end else if (bus.weights_load) begin
      thresh_reg <= thresh_in;
    end
  end
  assign thr = thresh_reg;
`else
  assign thr = THRESH_V;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      weight_reg <= '0;
    end else if (bus.weights_load) begin
      weight_reg <= bus.weights_data[8:0];
    end
  end

  // row_start restarts the fill count; a column arriving on the same edge is the first of the new row
  always_comb begin
    fill_next = fill_reg;
    if (bus.row_start) begin
      fill_next = 2'd0;
    end
    if (bus.d_valid && (fill_next != 2'd3)) begin
      fill_next = fill_next + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      win_reg  <= '0;
      fill_reg <= 2'd0;
      upd_reg  <= 1'b0;
      head_reg <= '0;
    end else begin
      fill_reg <= fill_next;
      upd_reg  <= bus.d_valid && (fill_next == 2'd3);
      if (bus.row_start) begin
        win_reg[0] <= '0;
        win_reg[1] <= '0;
        win_reg[2] <= bus.d_valid ? bus.d_in : 3'b000;
      end else if (bus.d_valid) begin
        win_reg[0] <= win_reg[1];
        win_reg[1] <= win_reg[2];
        win_reg[2] <= bus.d_in;
      end
      if (bus.d_valid) begin
        head_reg <= bus.col_idx - IDX_W'(2);
      end
    end
  end

  // Per-row match bits reduced to a 2-bit count: ones = parity, twos = majority
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic [2:0] row_match;
      assign row_match = ~({win_reg[2][gi], win_reg[1][gi], win_reg[0][gi]}
                           ^ weight_reg[3*gi +: 3]);
      assign row_cnt[gi] = {(row_match[0] & row_match[1]) |
                            (row_match[0] & row_match[2]) |
                            (row_match[1] & row_match[2]),
                            ^row_match};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s1_valid_reg <= 1'b0;
      s1_cnt_reg   <= '0;
      s1_idx_reg   <= '0;
    end else begin
      s1_valid_reg <= upd_reg;
      if (upd_reg) begin
        s1_cnt_reg <= row_cnt;
        s1_idx_reg <= head_reg;
      end
    end
  end

  assign pop_next = {2'b00, s1_cnt_reg[0]} + {2'b00, s1_cnt_reg[1]} + {2'b00, s1_cnt_reg[2]};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
      out_idx_reg   <= '0;
      pop_reg       <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        pop_reg     <= pop_next;
        out_bit_reg <= (pop_next >= thr);
        out_idx_reg <= s1_idx_reg;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_bit   = out_bit_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.popcount  = pop_reg;

endmodule

// File: tb/tb_conv_xnor_popcount_unit.sv
// Directed + light random stimulus with a timed scoreboard for conv_xnor_popcount_unit.
module tb_conv_xnor_popcount_unit;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] pop;
    logic       b;
    longint     due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [8:0] last_out;

  logic [8:0] m_w;
  logic [2:0] m_win [3];
  int         m_fill;
  logic [3:0] nidx;

  always #5 clk = ~clk;

  conv_xnor_popcount_unit_if #(.IDX_W(4)) bus_if ();

`ifdef CONV_THRESH_PORT_EN
  logic [3:0] thresh_in = 4'd5;
  conv_xnor_popcount_unit #(.THRESH(5), .IDX_W(4)) dut (
    .clk(clk), .reset_b(reset_b), .thresh_in(thresh_in), .bus(bus_if)
  );
`else
  conv_xnor_popcount_unit #(.THRESH(5), .IDX_W(4)) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus_if)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pop();
    logic [3:0] p = 4'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (m_win[c][r] == m_w[3*r+c]) p = p + 4'd1;
    return p;
  endfunction

  // Drive one cycle of inputs, then apply the same edge to the reference model
  task automatic step(input logic dv, input logic [2:0] d, input logic [3:0] idx,
                      input logic rs, input logic wl, input logic [15:0] wd);
    exp_t e;
    longint t;
    bus_if.d_valid      = dv;
    bus_if.d_in         = d;
    bus_if.col_idx      = idx;
    bus_if.row_start    = rs;
    bus_if.weights_load = wl;
    bus_if.weights_data = wd;
    @(posedge clk);
    t = longint'($time);
    if (wl) m_w = wd[8:0];
    if (rs) m_fill = 0;
    if (dv) begin
      m_win[0] = m_win[1];
      m_win[1] = m_win[2];
      m_win[2] = d;
      if (m_fill < 3) m_fill++;
      if (m_fill == 3) begin
        e.pop = model_pop();
        e.b   = (e.pop >= 4'd5);
        e.idx = idx - 4'd2;
        e.due = t + 20;
        q.push_back(e);
        $display("push col_idx=%0d data=%b -> exp idx=%0d pop=%0d bit=%0b", idx, d, e.idx, e.pop, e.b);
      end
    end
    #1;
  endtask

  task automatic col(input logic [2:0] d, input logic [3:0] idx);
    step(1'b1, d, idx, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (!reset_b) begin
      last_out = 9'd0;
    end else if (q.size() > 0 && q[0].due == longint'($time) - 5) begin
      mon_e = q.pop_front();
      check("out_valid", bus_if.out_valid, 1'b1);
      check("popcount", bus_if.popcount, mon_e.pop);
      check("out_bit", bus_if.out_bit, mon_e.b);
      check("out_idx", bus_if.out_idx, mon_e.idx);
      $display("result idx=%0d pop=%0d bit=%0b", bus_if.out_idx, bus_if.popcount, bus_if.out_bit);
    end else begin
      check("no_pulse", bus_if.out_valid, 1'b0);
      check("hold", {bus_if.out_bit, bus_if.out_idx, bus_if.popcount}, last_out);
    end
    last_out = {bus_if.out_bit, bus_if.out_idx, bus_if.popcount};
  end

  initial begin
    m_w = 9'd0;
    m_fill = 0;
    for (int c = 0; c < 3; c++) m_win[c] = 3'b000;
    bus_if.d_valid = 1'b0;
    bus_if.d_in = 3'b000;
    bus_if.col_idx = 4'd0;
    bus_if.row_start = 1'b0;
    bus_if.weights_load = 1'b0;
    bus_if.weights_data = 16'h0;
    #2;
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_popcount", bus_if.popcount, 4'd0);
    check("rst_out_idx", bus_if.out_idx, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;

    // All-ones weights, load together with row_start and the first column
    step(1'b1, 3'b111, 4'd0, 1'b1, 1'b1, 16'hFFFF);
    col(3'b111, 4'd1);
    col(3'b111, 4'd2);
    idle(3);

    // All-zero window, then a 4th column of ones
    step(1'b1, 3'b000, 4'd0, 1'b1, 1'b0, 16'h0);
    col(3'b000, 4'd1);
    col(3'b000, 4'd2);
    col(3'b111, 4'd3);
    idle(3);

    // Threshold boundary: 5 ones, then 4 ones
    step(1'b1, 3'b111, 4'd5, 1'b1, 1'b0, 16'h0);
    col(3'b011, 4'd6);
    col(3'b000, 4'd7);
    step(1'b1, 3'b111, 4'd5, 1'b1, 1'b0, 16'h0);
    col(3'b010, 4'd6);
    col(3'b000, 4'd7);
    idle(3);

    // Index wrap, back-to-back results
    step(1'b1, 3'b101, 4'd14, 1'b1, 1'b0, 16'h0);
    col(3'b011, 4'd15);
    col(3'b110, 4'd0);
    col(3'b001, 4'd1);
    idle(3);

    // row_start with d_valid after 5 columns
    for (int i = 0; i < 5; i++) col(3'(i), 4'(i));
    step(1'b1, 3'b100, 4'd5, 1'b1, 1'b0, 16'h0);
    col(3'b010, 4'd6);
    col(3'b111, 4'd7);
    idle(3);

    // Weight change mid-stream, on the same edge as a column
    step(1'b1, 3'b110, 4'd8, 1'b0, 1'b1, 16'h0155);
    col(3'b011, 4'd9);
    idle(3);

    // Light random traffic
    nidx = 4'd10;
    for (int i = 0; i < 30; i++) begin
      logic dv;
      dv = ($urandom_range(0, 3) != 0);
      step(dv, 3'($urandom_range(0, 7)), nidx, (i % 9) == 8, (i % 7) == 3,
           16'($urandom_range(0, 65535)));
      if (dv) nidx = nidx + 4'd1;
    end
    idle(3);

    // Reset while stage 1 holds a valid window and a result is on the outputs
    step(1'b1, 3'b111, 4'd0, 1'b1, 1'b1, 16'h01FF);
    col(3'b111, 4'd1);
    col(3'b111, 4'd2);
    col(3'b000, 4'd3);
    step(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 16'h0);
    reset_b = 1'b0;
    #1;
    check("mid_rst_out_valid", bus_if.out_valid, 1'b0);
    check("mid_rst_popcount", bus_if.popcount, 4'd0);
    check("mid_rst_out_bit", bus_if.out_bit, 1'b0);
    q.delete();
    m_w = 9'd0;
    m_fill = 0;
    for (int c = 0; c < 3; c++) m_win[c] = 3'b000;
    @(posedge clk);
    #1 reset_b = 1'b1;
    idle(2);
    // Weights read as zero until reloaded: an all-zero window matches every tap
    col(3'b000, 4'd4);
    col(3'b000, 4'd5);
    col(3'b000, 4'd6);
    col(3'b010, 4'd7);
    idle(1);

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    check("drain", q.size(), 0);
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_xnor_popcount_unit.md
Name: conv_xnor_popcount_unit

Overview:
- Compute stage directly downstream of the convolution datapath.
- Consumes one 3-bit input column per cycle (rows r0..r2 at one column index) and the 3x3 binary weight word; keeps a 3-column sliding window.
- Each output is an XNOR-popcount of the window against the weights, thresholded to one binary output bit with its write index.
- 2-stage pipeline: stage 1 is per-row XNOR plus ones/twos partial sums; stage 2 is the final sum and compare.

Parameters:
- THRESH, 5: an output bit is 1 when popcount >= THRESH (5 means signed ±1 sum >= 0 over 9 taps).
- IDX_W, 4: width of the column/write index.

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- weights_data  in  16  kernel word; bit (3*r+c) = weight at row r, column c; bits 15:9 ignored
- weights_load  in  1  capture weights_data into the internal weight register
- d_in  in  3  input column; bit r = row r
- d_valid  in  1  d_in/col_idx valid this cycle
- col_idx  in  IDX_W  column index of d_in
- row_start  in  1  clears the window before a new row
- out_valid  out  1  out_bit/out_idx valid
- out_bit  out  1  thresholded result
- out_idx  out  IDX_W  write index = index of the window's leftmost column
- popcount  out  4  XNOR match count, 0..9

Behaviour:
- Reset (async, reset_b=0): weight register=0, window=0, fill count=0, both pipeline stages invalid, out_valid=0, out_bit=0, out_idx=0, popcount=0.
- Window:
  - On a clk edge with d_valid=1: window shifts (col0<=col1, col1<=col2, col2<=d_in) and the fill count increments, saturating at 3.
  - Latched with the window: idx_head = col_idx - 2, modulo 2^IDX_W (wraps; col_idx=1 gives out_idx=15).
  - d_valid=0: window and fill count hold.
- row_start:
  - On a clk edge with row_start=1, fill count clears to 0.
  - If d_valid=1 on the same edge, d_in is loaded as col2 and the fill count becomes 1.
  - Pipeline contents already in flight are not cancelled.
- Stage 1 (edge after a window update that left fill=3):
  - Per row r, computes match bits m = ~(window_row_r ^ weight_row_r).
  - Registers a 2-bit count per row (ones = XOR of the three bits, twos = majority), the head index, and s1_valid.
  - Uses the weight register value at that edge.
- Stage 2 (next edge):
  - popcount = sum of the three 2-bit row counts (4 bits, max 9).
  - out_bit = (popcount >= THRESH).
  - out_idx = stage-1 index; out_valid = s1_valid.
- Latency: column accepted at edge t gives a result registered at edge t+2. out_valid is a 1-cycle pulse per full-window column.
- Throughput: one result per cycle under continuous d_valid.
- No backpressure. Outputs hold their last value while out_valid=0.
- weights_load:
  - The register updates at the edge.
  - A column accepted on that same edge is computed in stage 1 one edge later, so it uses the new weights.
  - Results already in stage 2 keep the old weights.
- Simultaneous weights_load, row_start and d_valid are all honoured as above, independently.
- Reset mid-operation flushes everything; no out_valid until 3 new columns arrive.

Optional Feature:
- Macro: CONV_THRESH_PORT_EN.
- Defined: adds input port thresh_in[3:0]. Its value is captured into a threshold register on weights_load (reset value THRESH), and stage 2 compares popcount against that register.
- Undefined: no thresh_in port; the compare uses parameter THRESH.

Test Plan:
- Weights 0x01FF loaded, row_start, then d_in=3'b111 at col_idx 0,1,2 -> single out_valid pulse 2 cycles after col 2: popcount=9, out_bit=1, out_idx=0.
- Weights 0x01FF, columns 3'b000 x3 -> popcount=0, out_bit=0. Then a 4th column 3'b111 at col_idx=3 -> next result popcount=3, out_idx=1.
- Threshold boundary with weights 0x01FF: window with 5 ones -> popcount=5, out_bit=1; window with 4 ones -> popcount=4, out_bit=0.
- Index wrap: columns at col_idx 14,15,0,1 continuous -> out_idx 14 then 15, back-to-back cycles.
- row_start asserted with d_valid after 5 columns -> no out_valid for the next 2 columns. The first new result arrives 2 edges after the 3rd column, with out_idx = that column's col_idx - 2.
- reset_b pulsed low mid-stream with stage 1 valid -> out_valid, popcount and out_bit at 0 immediately. No output until 3 fresh columns arrive; the weight register reads 0 until reloaded.
